// File: rtl/bo_datapath_pkg.sv
// Shared definitions for the bo_datapath operative block.
// Holds the ALU operation codes and the select codes for the three
// datapath muxes (operand A, operand B, write-back source).
package bo_datapath_pkg;

    // ALU operation, driven by the control signal h.
    typedef enum logic {
        OP_ADD = 1'b0,
        OP_MUL = 1'b1
    } alu_op_e;

    // Operand A source, driven by m0.
    typedef enum logic [1:0] {
        SELA_X  = 2'b00,
        SELA_H  = 2'b01,
        SELA_S  = 2'b10,
        SELA_KA = 2'b11
    } sel_a_e;

    // Operand B source, driven by m1.
    typedef enum logic [1:0] {
        SELB_X  = 2'b00,
        SELB_H  = 2'b01,
        SELB_KB = 2'b10,
        SELB_KC = 2'b11
    } sel_b_e;

    // Write-back source for H and S, driven by m2.
    typedef enum logic [1:0] {
        WB_ALU  = 2'b00,
        WB_X    = 2'b01,
        WB_ZERO = 2'b10,
        WB_SHR  = 2'b11
    } sel_wb_e;

endpackage

// File: rtl/bo_datapath_if.sv
// Bus between the control FSM and the bo_datapath operative block.
// Carries the operand input, the control word (m0/m1/m2/lx/ls/lh/h/done)
// and the captured result with its overflow flag and valid pulse.
//   master : control side, drives operand and control, reads result
//   slave  : datapath side, reads operand and control, drives result
interface bo_datapath_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] x_in;
    logic [1:0]       m0;
    logic [1:0]       m1;
    logic [1:0]       m2;
    logic             lx;
    logic             ls;
    logic             lh;
    logic             h;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             result_ovf;
    logic             result_valid;

    modport master (
        output x_in, m0, m1, m2, lx, ls, lh, h, done,
        input  result, result_ovf, result_valid
    );

    modport slave (
        input  x_in, m0, m1, m2, lx, ls, lh, h, done,
        output result, result_ovf, result_valid
    );
endinterface

// File: rtl/bo_datapath_alu.sv
// bo_alu: shared combinational ALU of the operative block.
// Ports:
//   a, b : operands (WIDTH)
//   op   : OP_ADD -> a+b mod 2^WIDTH, OP_MUL -> low WIDTH bits of a*b
//   y    : result (WIDTH)
//   ovf  : add carry-out, or nonzero upper half of the full product
module bo_alu
    import bo_datapath_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  alu_op_e          op,
    output logic [WIDTH-1:0] y,
    output logic             ovf
);

    logic [WIDTH:0]     sum;
    logic [2*WIDTH-1:0] prod;

    always_comb begin
        sum  = {1'b0, a} + {1'b0, b};
        prod = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
        y    = sum[WIDTH-1:0];
        ovf  = sum[WIDTH];
        if (op == OP_MUL) begin
            y   = prod[WIDTH-1:0];
            ovf = |prod[2*WIDTH-1:WIDTH];
        end
    end

endmodule

// File: rtl/bo_datapath.sv
// bo_datapath: operative block driven directly by the control FSM.
// Registers X (operand in), H (temporary), S (accumulator) around one
// shared add/multiply ALU. On done the next value of S and the sticky
// overflow flag are captured into the output registers and result_valid
// pulses for one cycle.
// Ports:
//   clk : rising-edge clock
//   rst : asynchronous active-high reset (clears all state)
//   bus : bo_datapath_if slave (x_in, m0/m1/m2, lx/ls/lh, h, done,
//         result, result_ovf, result_valid)
module bo_datapath
    import bo_datapath_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int KA    = 2,
    parameter int KB    = 3,
    parameter int KC    = 5
) (
    input  logic          clk,
    input  logic          rst,
    bo_datapath_if.slave  bus
);

    localparam logic [WIDTH-1:0] KA_V = WIDTH'(KA);
    localparam logic [WIDTH-1:0] KB_V = WIDTH'(KB);
    localparam logic [WIDTH-1:0] KC_V = WIDTH'(KC);

    logic [WIDTH-1:0] x_q, h_q, s_q;
    logic             ovf_q;

    logic [WIDTH-1:0] op_a, op_b, alu_y, wb, s_next;
    logic             alu_ovf, ovf_event, ovf_next;

    always_comb begin
        op_a = x_q;
        unique case (sel_a_e'(bus.m0))
            SELA_X:  op_a = x_q;
            SELA_H:  op_a = h_q;
            SELA_S:  op_a = s_q;
            SELA_KA: op_a = KA_V;
        endcase
    end

    always_comb begin
        op_b = x_q;
        unique case (sel_b_e'(bus.m1))
            SELB_X:  op_b = x_q;
            SELB_H:  op_b = h_q;
            SELB_KB: op_b = KB_V;
            SELB_KC: op_b = KC_V;
        endcase
    end

    bo_alu #(.WIDTH(WIDTH)) u_alu (
        .a   (op_a),
        .b   (op_b),
        .op  (alu_op_e'(bus.h)),
        .y   (alu_y),
        .ovf (alu_ovf)
    );

    always_comb begin
        wb = alu_y;
        unique case (sel_wb_e'(bus.m2))
            WB_ALU:  wb = alu_y;
            WB_X:    wb = x_q;
            WB_ZERO: wb = '0;
            WB_SHR:  wb = alu_y >> 1;
        endcase
    end

    // Overflow only counts when an ALU-derived value is actually written back.
    assign ovf_event = (bus.lh | bus.ls) && alu_ovf &&
                       ((sel_wb_e'(bus.m2) == WB_ALU) || (sel_wb_e'(bus.m2) == WB_SHR));
    assign ovf_next  = ovf_q | ovf_event;
    // Result capture sees S as it will be after this edge.
    assign s_next    = bus.ls ? wb : s_q;

    // Register stage: X/H/S, sticky overflow, output capture
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_q              <= '0;
            h_q              <= '0;
            s_q              <= '0;
            ovf_q            <= 1'b0;
            bus.result       <= '0;
            bus.result_ovf   <= 1'b0;
            bus.result_valid <= 1'b0;
        end else begin
            if (bus.lx) x_q <= bus.x_in;
            if (bus.lh) h_q <= wb;
            if (bus.ls) s_q <= wb;
            bus.result_valid <= bus.done;
            if (bus.done) begin
                bus.result     <= s_next;
                bus.result_ovf <= ovf_next;
                ovf_q          <= 1'b0;
            end else begin
                ovf_q <= ovf_next;
            end
        end
    end

endmodule
